seq_alu: RTL
============

# seq_alu

Parametrised, multi-cycle successor to the combinational ALU. It keeps the same 4-bit opcode map, adds WIDTH generalisation, and adds status flags, a remainder output, iterative shift-add multiply and restoring divide, and valid/ready handshakes on both the operand side and the result side. It sits between the control sequencer and the accumulator. The control unit presents operands from acc/mbr and stalls on in_ready/out_valid instead of assuming single-cycle results.

## Interface
- WIDTH, 16, operand/result width in bits (>= 4)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request; high only in IDLE while reset is high
- opcode  in  4  operation select, map below
- operand1  in  WIDTH  first operand (A)
- operand2  in  WIDTH  second operand (B)
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- remainder  out  WIDTH  DIV remainder; 0 for all other ops
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- carry  out  1  carry/borrow/shifted-out bit, per opcode
- overflow  out  1  signed overflow (ADD/SUB only)
- div_by_zero  out  1  DIV with B == 0

## Operation
- Opcode map:
  - 0000 ADD; 0001 SUB; 0010 MUL; 0011 DIV (unsigned)
  - 0100 SHL; 0101 SHR; 0110 ROL; 0111 ROR (A only, by 1)
  - 1000 AND; 1001 OR; 1010 XOR; 1011 NOR; 1100 NAND; 1101 XNOR
  - 1110 A>B unsigned (1/0); 1111 A==B (1/0)
- Handshake:
  - Accept = in_valid && in_ready.
  - Opcode and operands are latched on accept; the inputs are don't-care afterwards.
  - Result is consumed when out_valid && out_ready.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, accept of MUL → MUL. Iteration counter loaded with WIDTH-1, product accumulator 2*WIDTH bits cleared.
  - IDLE, accept of DIV with B≠0 → DIV. Counter loaded with WIDTH-1, partial remainder cleared.
  - IDLE, accept of any other opcode, or DIV with B==0 → DONE, with outputs registered from the combinational path.
  - MUL/DIV: one iteration per cycle (one bit per cycle). Transition to DONE on the cycle the counter reaches 0.
  - DONE: out_valid=1. On out_ready → IDLE.
- Width and flag rules:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum. overflow = sign(A)==sign(B) && sign(result)≠sign(A).
  - SUB: carry = borrow (A<B unsigned). overflow = sign(A)≠sign(B) && sign(result)≠sign(A).
  - MUL: result = low WIDTH bits of product; carry = OR of the high WIDTH bits.
  - DIV: result = quotient, remainder = A mod B.
  - DIV by zero: result = all ones, remainder = A, div_by_zero=1, carry=0.
  - SHL/ROL: carry = A[WIDTH-1]. SHR/ROR: carry = A[0].
  - Logic and compare ops: carry=0.
  - overflow=0 for every op except ADD/SUB. div_by_zero=0 except DIV with B==0.
  - zero and negative always derived from the final result.
- Output stability: result, remainder and flags are registered. They hold steady from out_valid rising until the consuming edge, and keep their last values in IDLE until the next op completes.
- Reset (reset==0 at posedge), including mid-operation:
  - state → IDLE; the in-flight op is discarded.
  - out_valid, result, remainder and all flags → 0.
  - in_ready=0 while reset is low.

## Timing
- in_ready is combinational: (state==IDLE) && reset. No new request is accepted in MUL, DIV or DONE (no overlap).
- Latency from the accept edge to out_valid high:
  - Single-cycle ops and DIV by zero: 1 cycle.
  - MUL and DIV: WIDTH+1 cycles (17 at WIDTH=16).
- out_valid is held indefinitely under backpressure. Consume edge → IDLE, so in_ready is high the following cycle.
- Peak throughput:
  - One single-cycle op per 2 cycles with out_ready tied high.
  - One MUL/DIV per WIDTH+2 cycles.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored and no state is captured.

## Test plan
- Reset low for 2 cycles → all outputs 0, in_ready=0. After release → in_ready=1.
- ADD FFFF+0001 → result 0000, carry=1, zero=1, overflow=0, out_valid 1 cycle after accept. ADD 7FFF+0001 → 8000, overflow=1, negative=1, carry=0.
- MUL 0100×0100 → result 0000, carry=1, out_valid 17 cycles after accept. MUL 012C×00C8 → EA60, carry=0, negative=1.
- DIV 03E8/0007 → result 008E, remainder 0006, latency 17. DIV 1234/0000 → FFFF, remainder 1234, div_by_zero=1, latency 1.
- SHR 0003 → 0001, carry=1. ROL 8001 → 0003, carry=1. Compare 0005>0003 → 0001. Compare 0005==0003 → 0000, zero=1.
- Backpressure:
  - Hold out_ready low 5 cycles after a SUB 0003-0005 → result FFFE, carry=1, stable throughout.
  - in_ready=0 and in_valid pulses are ignored.
- Reset mid-op: assert reset at iteration 8 of a MUL → next edge all outputs 0, no out_valid. Following ADD 0002+0003 → 0005.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the control sequencer and seq_alu.
// The master side (control unit) presents requests and consumes results;
// the slave side (seq_alu) accepts requests and produces results and flags.
interface seq_alu_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, opcode, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, remainder,
               zero, negative, carry, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, opcode, operand1, operand2, out_ready,
        output in_ready, out_valid, result, remainder,
               zero, negative, carry, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops are computed straight from the request inputs on the
// accept edge; MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
// All results and flags are held in output registers until the next op ends.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_r, state_nxt_s;
    logic   out_valid_r;
    logic   in_ready_s, accept_s, start_mul_s, start_div_s, ld_out_s;

    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] prod_r, mcand_r, prod_nxt_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   prem_r, dvd_r, div_b_r, rem_nxt_s, quot_nxt_s;
    logic [WIDTH:0]     trial_s;
    logic               qbit_s;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] alu_res_s, alu_rem_s;
    logic             alu_carry_s, alu_ovf_s, alu_dbz_s;

    logic [WIDTH-1:0] fin_res_s, fin_rem_s;
    logic             fin_carry_s, fin_ovf_s, fin_dbz_s;

    logic [WIDTH-1:0] result_r, remainder_r;
    logic             zero_r, negative_r, carry_r, overflow_r, dbz_r;

    // State register and registered out_valid, cleared by reset mid-operation
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Next-state logic: route accepted ops to MUL, DIV or straight to DONE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_mul_s)      state_nxt_s = ST_MUL;
                else if (start_div_s) state_nxt_s = ST_DIV;
                else if (accept_s)    state_nxt_s = ST_DONE;
                else                  state_nxt_s = ST_IDLE;
            end
            ST_MUL, ST_DIV: begin
                if (cnt_r == {CW{1'b0}}) state_nxt_s = ST_DONE;
                else                     state_nxt_s = state_r;
            end
            ST_DONE: begin
                if (bus.out_ready) state_nxt_s = ST_IDLE;
                else               state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control strobes: handshake accept, iteration start and output load
    always_comb begin
        in_ready_s  = 1'b0;
        accept_s    = 1'b0;
        start_mul_s = 1'b0;
        start_div_s = 1'b0;
        ld_out_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = reset;
                accept_s   = reset & bus.in_valid;
                if (accept_s) begin
                    if (bus.opcode == OP_MUL)
                        start_mul_s = 1'b1;
                    else if ((bus.opcode == OP_DIV) && (bus.operand2 != {WIDTH{1'b0}}))
                        start_div_s = 1'b1;
                    else
                        ld_out_s = 1'b1;
                end else begin
                    ld_out_s = 1'b0;
                end
            end
            ST_MUL, ST_DIV: ld_out_s = (cnt_r == {CW{1'b0}});
            ST_DONE:        ld_out_s = 1'b0;
            default:        ld_out_s = 1'b0;
        endcase
    end

    assign sum_s  = {1'b0, bus.operand1} + {1'b0, bus.operand2};
    assign diff_s = bus.operand1 - bus.operand2;

    // Single-cycle datapath evaluated directly from the request operands
    always_comb begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_rem_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        alu_dbz_s   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                              (sum_s[WIDTH-1] != bus.operand1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s;
                alu_carry_s = (bus.operand1 < bus.operand2);
                alu_ovf_s   = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                              (diff_s[WIDTH-1] != bus.operand1[WIDTH-1]);
            end
            // Only a zero divisor finishes a DIV from here
            OP_DIV: begin
                alu_res_s = {WIDTH{1'b1}};
                alu_rem_s = bus.operand1;
                alu_dbz_s = 1'b1;
            end
            OP_SHL: begin
                alu_res_s   = {bus.operand1[WIDTH-2:0], 1'b0};
                alu_carry_s = bus.operand1[WIDTH-1];
            end
            OP_SHR: begin
                alu_res_s   = {1'b0, bus.operand1[WIDTH-1:1]};
                alu_carry_s = bus.operand1[0];
            end
            OP_ROL: begin
                alu_res_s   = {bus.operand1[WIDTH-2:0], bus.operand1[WIDTH-1]};
                alu_carry_s = bus.operand1[WIDTH-1];
            end
            OP_ROR: begin
                alu_res_s   = {bus.operand1[0], bus.operand1[WIDTH-1:1]};
                alu_carry_s = bus.operand1[0];
            end
            OP_AND:  alu_res_s = bus.operand1 & bus.operand2;
            OP_OR:   alu_res_s = bus.operand1 | bus.operand2;
            OP_XOR:  alu_res_s = bus.operand1 ^ bus.operand2;
            OP_NOR:  alu_res_s = ~(bus.operand1 | bus.operand2);
            OP_NAND: alu_res_s = ~(bus.operand1 & bus.operand2);
            OP_XNOR: alu_res_s = ~(bus.operand1 ^ bus.operand2);
            OP_GT:   alu_res_s = {{(WIDTH-1){1'b0}}, (bus.operand1 > bus.operand2)};
            OP_EQ:   alu_res_s = {{(WIDTH-1){1'b0}}, (bus.operand1 == bus.operand2)};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add step and one restoring-divide step per cycle
    assign prod_nxt_s = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    assign trial_s    = {prem_r, dvd_r[WIDTH-1]} - {1'b0, div_b_r};
    assign qbit_s     = ~trial_s[WIDTH];
    assign rem_nxt_s  = qbit_s ? trial_s[WIDTH-1:0] : {prem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
    assign quot_nxt_s = {dvd_r[WIDTH-2:0], qbit_s};

    // Iteration registers: load on accept, step while in MUL or DIV
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r    <= {CW{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            prem_r   <= {WIDTH{1'b0}};
            dvd_r    <= {WIDTH{1'b0}};
            div_b_r  <= {WIDTH{1'b0}};
        end else if (start_mul_s) begin
            cnt_r    <= CNT_LOAD;
            prod_r   <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, bus.operand1};
            mplier_r <= bus.operand2;
        end else if (start_div_s) begin
            cnt_r   <= CNT_LOAD;
            prem_r  <= {WIDTH{1'b0}};
            dvd_r   <= bus.operand1;
            div_b_r <= bus.operand2;
        end else if (state_r == ST_MUL) begin
            cnt_r    <= cnt_r - CNT_ONE;
            prod_r   <= prod_nxt_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        end else if (state_r == ST_DIV) begin
            cnt_r  <= cnt_r - CNT_ONE;
            prem_r <= rem_nxt_s;
            dvd_r  <= quot_nxt_s;
        end
    end

    // Select the finished value: request path in IDLE, last iteration otherwise
    always_comb begin
        fin_res_s   = {WIDTH{1'b0}};
        fin_rem_s   = {WIDTH{1'b0}};
        fin_carry_s = 1'b0;
        fin_ovf_s   = 1'b0;
        fin_dbz_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                fin_res_s   = alu_res_s;
                fin_rem_s   = alu_rem_s;
                fin_carry_s = alu_carry_s;
                fin_ovf_s   = alu_ovf_s;
                fin_dbz_s   = alu_dbz_s;
            end
            ST_MUL: begin
                fin_res_s   = prod_nxt_s[WIDTH-1:0];
                fin_carry_s = |prod_nxt_s[2*WIDTH-1:WIDTH];
            end
            ST_DIV: begin
                fin_res_s = quot_nxt_s;
                fin_rem_s = rem_nxt_s;
            end
            ST_DONE: fin_res_s = {WIDTH{1'b0}};
            default: fin_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Output registers: loaded once per op, held through DONE and IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_r    <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            negative_r  <= 1'b0;
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            dbz_r       <= 1'b0;
        end else if (ld_out_s) begin
            result_r    <= fin_res_s;
            remainder_r <= fin_rem_s;
            zero_r      <= (fin_res_s == {WIDTH{1'b0}});
            negative_r  <= fin_res_s[WIDTH-1];
            carry_r     <= fin_carry_s;
            overflow_r  <= fin_ovf_s;
            dbz_r       <= fin_dbz_s;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.result      = result_r;
    assign bus.remainder   = remainder_r;
    assign bus.zero        = zero_r;
    assign bus.negative    = negative_r;
    assign bus.carry       = carry_r;
    assign bus.overflow    = overflow_r;
    assign bus.div_by_zero = dbz_r;
endmodule
